// File: rtl/pwm_pkg.sv
// Shared constants and helpers for the multi-channel PWM controller.
// Holds default parameters, saturating duty arithmetic and the select-width helper.
package pwm_pkg;

  localparam int NCH_D      = 4;
  localparam int CW_D       = 8;
  localparam int PERIOD_D   = 10;
  localparam int STEP_D     = 1;
  localparam int DUTY_RST_D = 5;
  localparam int DEB_DIV_D  = 2;

  // One bit wider than any supported duty width, so a sum never wraps.
  typedef logic [32:0] wide_t;

  function automatic int sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic wide_t sat_add(
    input wide_t a,
    input wide_t s,
    input wide_t lim
  );
    wide_t r;
    r = a + s;
    return (r > lim) ? lim : r;
  endfunction

  function automatic wide_t sat_sub(
    input wide_t a,
    input wide_t s
  );
    return (a < s) ? '0 : a - s;
  endfunction

endpackage

// File: rtl/pwm_multi_ctrl_btn_debounce.sv
// Button debouncer: two tick-gated flops, one-clock pulse per press.
// Ports: clk, rst_n, tick (sample strobe), btn (raw), evt (press pulse).
module btn_debounce (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic btn,
  output logic evt
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else if (tick) begin
      r_s1 <= btn;
      r_s2 <= r_s1;
    end
  end

  assign evt = r_s1 & ~r_s2 & tick;

endmodule

// File: rtl/pwm_multi_ctrl.sv
// Multi-channel PWM with debounced button duty adjust; macro PWM_SHADOW_EN
// shadows duty to period boundaries. Ports: clk, rst_n, ena, btn_inc, btn_dec,
// ch_sel, pwm_out, duty_o, period_wrap.
module pwm_multi_ctrl
  import pwm_pkg::*;
#(
  parameter int NCH      = NCH_D,
  parameter int CW       = CW_D,
  parameter int PERIOD   = PERIOD_D,
  parameter int STEP     = STEP_D,
  parameter int DUTY_RST = DUTY_RST_D,
  parameter int DEB_DIV  = DEB_DIV_D
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    btn_inc,
  input  logic                    btn_dec,
  input  logic [sel_w(NCH)-1:0]   ch_sel,
  output logic [NCH-1:0]          pwm_out,
  output logic [CW-1:0]           duty_o,
  output logic                    period_wrap
);

  localparam int DW = (DEB_DIV > 1) ? $clog2(DEB_DIV) : 1;

  logic [DW-1:0]  r_div;
  logic [CW-1:0]  r_cnt;
  logic [CW-1:0]  r_tgt [NCH];
  logic [NCH-1:0] r_pwm;

  logic           w_tick;
  logic           w_wrap;
  logic           w_inc;
  logic           w_dec;
  logic [CW-1:0]  w_tgt_nxt [NCH];
  logic [CW-1:0]  w_act [NCH];

  assign w_tick = (r_div == DW'(DEB_DIV - 1)) & ena;
  assign w_wrap = (r_cnt == CW'(PERIOD - 1)) & ena;

  btn_debounce u_deb_inc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .btn   (btn_inc),
    .evt   (w_inc)
  );

  btn_debounce u_deb_dec (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick),
    .btn   (btn_dec),
    .evt   (w_dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_cnt <= '0;
    end else if (ena) begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
    end
  end

  // Simultaneous inc and dec cancel; out-of-range selects match no channel.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_tgt_nxt[i] = r_tgt[i];
      if (int'(ch_sel) == i && (w_inc ^ w_dec)) begin
        if (w_inc)
          w_tgt_nxt[i] = CW'(sat_add(wide_t'(r_tgt[i]),
                                     wide_t'(STEP),
                                     wide_t'(PERIOD)));
        else
          w_tgt_nxt[i] = CW'(sat_sub(wide_t'(r_tgt[i]),
                                     wide_t'(STEP)));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++)
        r_tgt[i] <= CW'(DUTY_RST);
    end else begin
      for (int i = 0; i < NCH; i++)
        r_tgt[i] <= w_tgt_nxt[i];
    end
  end

`ifdef PWM_SHADOW_EN
  logic [CW-1:0] r_act [NCH];

  // Copy on the last count so a same-edge update lands in the next period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++)
        r_act[i] <= CW'(DUTY_RST);
    end else if (w_wrap) begin
      for (int i = 0; i < NCH; i++)
        r_act[i] <= w_tgt_nxt[i];
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++)
      w_act[i] = r_act[i];
  end
`else
  always_comb begin
    for (int i = 0; i < NCH; i++)
      w_act[i] = r_tgt[i];
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= '0;
    end else begin
      for (int i = 0; i < NCH; i++)
        r_pwm[i] <= ena & (r_cnt < w_act[i]);
    end
  end

  always_comb begin
    duty_o = '0;
    for (int i = 0; i < NCH; i++)
      if (int'(ch_sel) == i)
        duty_o = r_tgt[i];
  end

  assign pwm_out     = r_pwm;
  assign period_wrap = w_wrap;

endmodule
